// File: rtl/btb_pkg.sv
// Shared BTB types: index/tag/target widths and the update packet written into the BTB.
package btb_pkg;

    localparam int BTB_IDX_W       = 5;
    localparam int BTB_TAG_W       = 8;
    localparam int BTB_DATA_W      = 30;
    localparam int BTB_DEPTH       = 4;
    localparam int NUM_BTB_ENTRIES = 2 ** BTB_IDX_W;

    typedef logic [BTB_IDX_W-1:0]  BTB_IDX;
    typedef logic [BTB_TAG_W-1:0]  BTB_TAG;
    typedef logic [BTB_DATA_W-1:0] BTB_DATA;

    typedef struct packed {
        BTB_IDX  idx;
        BTB_TAG  tag;
        BTB_DATA data;
    } BTB_UPD_PACKET;

endpackage

// File: rtl/btb_upd_cam.sv
// DEPTH-way compare of queued entries against a key; reports every match and the youngest one.
module btb_upd_cam
    import btb_pkg::*;
#(
    parameter int DEPTH = BTB_DEPTH,
    parameter int IDX_W = BTB_IDX_W,
    parameter int TAG_W = BTB_TAG_W,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0][IDX_W-1:0] ent_idx,
    input  logic [DEPTH-1:0][TAG_W-1:0] ent_tag,
    input  logic [DEPTH-1:0]            live,
    input  logic [PTR_W-1:0]            head,
    input  logic [IDX_W-1:0]            key_idx,
    input  logic [TAG_W-1:0]            key_tag,
    input  logic                        use_tag,
    output logic [DEPTH-1:0]            match,
    output logic [PTR_W-1:0]            sel
);

    logic [PTR_W-1:0] slot;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = live[i] && (ent_idx[i] == key_idx) &&
                       (!use_tag || (ent_tag[i] == key_tag));
        end
    end

    // Walk from oldest (head) to youngest so the last hit seen is the youngest.
    always_comb begin
        sel  = head;
        slot = head;
        for (int k = 0; k < DEPTH; k++) begin
            slot = head + PTR_W'(k);
            if (match[slot]) begin
                sel = slot;
            end
        end
    end

endmodule

// File: rtl/btb_update_ctrl.sv
// Coalescing queue between branch retire and the single-write-port BTB, with fetch forwarding.
module btb_update_ctrl
    import btb_pkg::*;
#(
    parameter int IDX_W  = BTB_IDX_W,
    parameter int TAG_W  = BTB_TAG_W,
    parameter int DATA_W = BTB_DATA_W,
    parameter int DEPTH  = BTB_DEPTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [1:0]             upd_valid,
    input  logic [1:0][IDX_W-1:0]  upd_idx,
    input  logic [1:0][TAG_W-1:0]  upd_tag,
    input  logic [1:0][DATA_W-1:0] upd_data,
    output logic                   upd_ready,
    output logic                   btb_wr_en,
    output logic [IDX_W-1:0]       btb_wr_idx,
    output logic [TAG_W-1:0]       btb_wr_tag,
    output logic [DATA_W-1:0]      btb_wr_data,
    input  logic [IDX_W-1:0]       lk_idx,
    input  logic [TAG_W-1:0]       lk_tag,
    output logic                   fwd_valid,
    output logic [DATA_W-1:0]      fwd_data,
    output logic                   err_overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Handshake: a request on upd_valid[r] is taken at the rising edge; upd_ready is
    // a registered-state capacity hint (two free slots), never a function of upd_valid.

    logic                          rst_meta;
    logic                          rst_sync_n;

    logic [DEPTH-1:0][IDX_W-1:0]   ent_idx;
    logic [DEPTH-1:0][TAG_W-1:0]   ent_tag;
    logic [DEPTH-1:0][DATA_W-1:0]  ent_data;
    logic [DEPTH-1:0]              live;
    logic [PTR_W-1:0]              head;
    logic [PTR_W-1:0]              tail;
    logic [CNT_W-1:0]              count;

    logic                          pop;
    logic [DEPTH-1:0]              coal_live;
    logic [1:0][DEPTH-1:0]         push_match;
    logic [1:0][PTR_W-1:0]         push_sel;
    logic [DEPTH-1:0]              fwd_match;
    logic [PTR_W-1:0]              fwd_sel;
    logic                          eff0;
    logic                          eff1;
    logic                          co0;
    logic                          co1;
    logic                          alloc0;
    logic                          alloc1;
    logic [CNT_W-1:0]              free_slots;
    logic [PTR_W-1:0]              tail1;
    logic [CNT_W-1:0]              count_next;

    // Reset asserts asynchronously but releases on a clock edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rst_meta   <= 1'b0;
            rst_sync_n <= 1'b0;
        end else begin
            rst_meta   <= 1'b1;
            rst_sync_n <= rst_meta;
        end
    end

    for (genvar r = 0; r < 2; r++) begin : g_push_cam
        btb_upd_cam #(
            .DEPTH (DEPTH),
            .IDX_W (IDX_W),
            .TAG_W (TAG_W)
        ) u_push_cam (
            .ent_idx (ent_idx),
            .ent_tag (ent_tag),
            .live    (coal_live),
            .head    (head),
            .key_idx (upd_idx[r]),
            .key_tag (upd_tag[r]),
            .use_tag (1'b0),
            .match   (push_match[r]),
            .sel     (push_sel[r])
        );
    end

    btb_upd_cam #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_fwd_cam (
        .ent_idx (ent_idx),
        .ent_tag (ent_tag),
        .live    (live),
        .head    (head),
        .key_idx (lk_idx),
        .key_tag (lk_tag),
        .use_tag (1'b1),
        .match   (fwd_match),
        .sel     (fwd_sel)
    );

    // The head always drains this cycle, so it is never a coalescing target.
    always_comb begin
        pop       = (count != '0);
        coal_live = live;
        if (pop) begin
            coal_live[head] = 1'b0;
        end
    end

    always_comb begin
        eff0       = upd_valid[0] && !(upd_valid[1] && (upd_idx[0] == upd_idx[1]));
        eff1       = upd_valid[1];
        co0        = eff0 && (|push_match[0]);
        co1        = eff1 && (|push_match[1]);
        free_slots = CNT_W'(DEPTH) - count;
        alloc0     = eff0 && !co0 && (free_slots != '0);
        alloc1     = eff1 && !co1 && (free_slots > CNT_W'(alloc0));
        tail1      = tail + PTR_W'(alloc0);
        count_next = count + CNT_W'(alloc0) + CNT_W'(alloc1) - CNT_W'(pop);
    end

    always_ff @(posedge clock or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            ent_idx      <= '0;
            ent_tag      <= '0;
            ent_data     <= '0;
            live         <= '0;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            err_overflow <= 1'b0;
        end else begin
            if (pop) begin
                live[head] <= 1'b0;
            end
            if (co0) begin
                ent_tag[push_sel[0]]  <= upd_tag[0];
                ent_data[push_sel[0]] <= upd_data[0];
            end
            if (alloc0) begin
                ent_idx[tail]  <= upd_idx[0];
                ent_tag[tail]  <= upd_tag[0];
                ent_data[tail] <= upd_data[0];
                live[tail]     <= 1'b1;
            end
            if (co1) begin
                ent_tag[push_sel[1]]  <= upd_tag[1];
                ent_data[push_sel[1]] <= upd_data[1];
            end
            if (alloc1) begin
                ent_idx[tail1]  <= upd_idx[1];
                ent_tag[tail1]  <= upd_tag[1];
                ent_data[tail1] <= upd_data[1];
                live[tail1]     <= 1'b1;
            end
            head  <= head + PTR_W'(pop);
            tail  <= tail + PTR_W'(alloc0) + PTR_W'(alloc1);
            count <= count_next;
            if ((upd_valid != 2'b00) && !upd_ready) begin
                err_overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        upd_ready   = (count <= CNT_W'(DEPTH - 2));
        btb_wr_en   = pop;
        btb_wr_idx  = pop ? ent_idx[head]  : '0;
        btb_wr_tag  = pop ? ent_tag[head]  : '0;
        btb_wr_data = pop ? ent_data[head] : '0;
        fwd_valid   = |fwd_match;
        fwd_data    = (|fwd_match) ? ent_data[fwd_sel] : '0;
    end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed and randomized checks of the BTB update queue against a queue-based reference.
module tb_btb_update_ctrl;
    import btb_pkg::*;

    localparam int IDX_W  = BTB_IDX_W;
    localparam int TAG_W  = BTB_TAG_W;
    localparam int DATA_W = BTB_DATA_W;
    localparam int DEPTH  = BTB_DEPTH;

    logic                   clock = 1'b0;
    logic                   reset = 1'b0;
    logic [1:0]             upd_valid;
    logic [1:0][IDX_W-1:0]  upd_idx;
    logic [1:0][TAG_W-1:0]  upd_tag;
    logic [1:0][DATA_W-1:0] upd_data;
    logic                   upd_ready;
    logic                   btb_wr_en;
    logic [IDX_W-1:0]       btb_wr_idx;
    logic [TAG_W-1:0]       btb_wr_tag;
    logic [DATA_W-1:0]      btb_wr_data;
    logic [IDX_W-1:0]       lk_idx;
    logic [TAG_W-1:0]       lk_tag;
    logic                   fwd_valid;
    logic [DATA_W-1:0]      fwd_data;
    logic                   err_overflow;

    BTB_UPD_PACKET exp_q[$];
    logic          exp_ovf;
    int            total;
    int            bad;
    BTB_UPD_PACKET nil;
    BTB_UPD_PACKET ra;
    BTB_UPD_PACKET rb;

    btb_update_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .upd_valid    (upd_valid),
        .upd_idx      (upd_idx),
        .upd_tag      (upd_tag),
        .upd_data     (upd_data),
        .upd_ready    (upd_ready),
        .btb_wr_en    (btb_wr_en),
        .btb_wr_idx   (btb_wr_idx),
        .btb_wr_tag   (btb_wr_tag),
        .btb_wr_data  (btb_wr_data),
        .lk_idx       (lk_idx),
        .lk_tag       (lk_tag),
        .fwd_valid    (fwd_valid),
        .fwd_data     (fwd_data),
        .err_overflow (err_overflow)
    );

    always #5 clock = ~clock;

    function automatic BTB_UPD_PACKET pk(input BTB_IDX i, input BTB_TAG t, input BTB_DATA d);
        BTB_UPD_PACKET p;
        p.idx  = i;
        p.tag  = t;
        p.data = d;
        return p;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at the falling edge, check pre-edge outputs, advance the reference.
    task automatic step(input logic [1:0] v, input BTB_UPD_PACKET p0, input BTB_UPD_PACKET p1,
                        input BTB_IDX li, input BTB_TAG lt);
        BTB_UPD_PACKET p;
        logic          exp_ready;
        logic          exp_fwd;
        BTB_DATA       exp_fd;
        int            base;
        int            allocs;
        bit            found;
        upd_valid   = v;
        upd_idx[0]  = p0.idx;
        upd_tag[0]  = p0.tag;
        upd_data[0] = p0.data;
        upd_idx[1]  = p1.idx;
        upd_tag[1]  = p1.tag;
        upd_data[1] = p1.data;
        lk_idx      = li;
        lk_tag      = lt;
        #1;
        exp_ready = (DEPTH - exp_q.size()) >= 2;
        chk("upd_ready", 64'(upd_ready), 64'(exp_ready));
        chk("count", 64'(dut.count), 64'(exp_q.size()));
        chk("err_overflow", 64'(err_overflow), 64'(exp_ovf));
        if (exp_q.size() != 0) begin
            chk("wr_en", 64'(btb_wr_en), 64'(1'b1));
            chk("wr_pkt", 64'({btb_wr_idx, btb_wr_tag, btb_wr_data}), 64'(exp_q[0]));
        end else begin
            chk("wr_en_idle", 64'(btb_wr_en), 64'(1'b0));
        end
        exp_fwd = 1'b0;
        exp_fd  = '0;
        foreach (exp_q[k]) begin
            if (exp_q[k].idx == li && exp_q[k].tag == lt) begin
                exp_fwd = 1'b1;
                exp_fd  = exp_q[k].data;
            end
        end
        chk("fwd_valid", 64'(fwd_valid), 64'(exp_fwd));
        if (exp_fwd) begin
            chk("fwd_data", 64'(fwd_data), 64'(exp_fd));
        end
        if (v != 2'b00 && !exp_ready) begin
            exp_ovf = 1'b1;
        end
        base = exp_q.size();
        if (base != 0) begin
            void'(exp_q.pop_front());
        end
        allocs = 0;
        for (int r = 0; r < 2; r++) begin
            p = (r == 0) ? p0 : p1;
            if (!v[r]) continue;
            if (r == 0 && v[1] && p0.idx == p1.idx) continue;
            found = 1'b0;
            foreach (exp_q[k]) begin
                if (exp_q[k].idx == p.idx) begin
                    exp_q[k].tag  = p.tag;
                    exp_q[k].data = p.data;
                    found = 1'b1;
                end
            end
            if (!found && (base + allocs) < DEPTH) begin
                exp_q.push_back(p);
                allocs++;
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(2'b00, nil, nil, '0, '0);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        exp_ovf   = 1'b0;
        nil       = '0;
        upd_valid = '0;
        upd_idx   = '0;
        upd_tag   = '0;
        upd_data  = '0;
        lk_idx    = '0;
        lk_tag    = '0;

        // reset state
        repeat (2) @(negedge clock);
        #1;
        chk("rst_wr_en", 64'(btb_wr_en), 64'(1'b0));
        chk("rst_ready", 64'(upd_ready), 64'(1'b1));
        chk("rst_fwd", 64'(fwd_valid), 64'(1'b0));
        chk("rst_ovf", 64'(err_overflow), 64'(1'b0));
        chk("rst_wr_pkt", 64'({btb_wr_idx, btb_wr_tag, btb_wr_data}), 64'(0));
        chk("rst_fwd_data", 64'(fwd_data), 64'(0));
        reset = 1'b1;
        @(negedge clock);
        idle(3);

        // single push, drained one cycle later
        step(2'b01, pk(5'd3, 8'h12, 30'h100), nil, '0, '0);
        idle(3);

        // two ports on consecutive cycles with recurring indices
        step(2'b11, pk(5'd5, 8'h01, 30'h501), pk(5'd6, 8'h01, 30'h601), '0, '0);
        step(2'b11, pk(5'd5, 8'h02, 30'h502), pk(5'd6, 8'h02, 30'h602), '0, '0);
        step(2'b11, pk(5'd5, 8'h03, 30'h503), pk(5'd6, 8'h03, 30'h603), '0, '0);
        idle(4);

        // distinct indices fill to DEPTH-1 and drop upd_ready
        step(2'b11, pk(5'd5, 8'h04, 30'h504), pk(5'd6, 8'h04, 30'h604), '0, '0);
        step(2'b11, pk(5'd7, 8'h04, 30'h704), pk(5'd8, 8'h04, 30'h804), '0, '0);
        idle(4);

        // coalesce into a non-head entry
        step(2'b11, pk(5'd1, 8'h11, 30'h111), pk(5'd2, 8'h11, 30'h222), '0, '0);
        step(2'b01, pk(5'd7, 8'h77, 30'hAAAA), nil, '0, '0);
        step(2'b01, pk(5'd7, 8'h77, 30'hBBBB), nil, 5'd7, 8'h77);
        idle(4);

        // same-cycle collision
        step(2'b11, pk(5'd9, 8'h09, 30'hA9), pk(5'd9, 8'h09, 30'hB9), '0, '0);
        idle(3);

        // forwarding hit and tag miss
        step(2'b11, pk(5'd12, 8'h22, 30'hC12), pk(5'd4, 8'h22, 30'h4444), 5'd4, 8'h22);
        step(2'b00, nil, nil, 5'd4, 8'h22);
        step(2'b00, nil, nil, 5'd4, 8'h23);
        step(2'b00, nil, nil, 5'd4, 8'h22);
        idle(2);

        // random traffic over a small index range, pushes regardless of upd_ready
        for (int n = 0; n < 60; n++) begin
            ra = pk(BTB_IDX'($urandom_range(0, 3)), BTB_TAG'($urandom_range(0, 1)), BTB_DATA'($urandom));
            rb = pk(BTB_IDX'($urandom_range(0, 3)), BTB_TAG'($urandom_range(0, 1)), BTB_DATA'($urandom));
            step(2'($urandom_range(0, 3)), ra, rb, BTB_IDX'($urandom_range(0, 3)), BTB_TAG'($urandom_range(0, 1)));
        end
        idle(5);

        // forced overflow, sticky, then reset in the middle of draining
        step(2'b11, pk(5'd20, 8'h01, 30'h20), pk(5'd21, 8'h01, 30'h21), '0, '0);
        step(2'b11, pk(5'd22, 8'h01, 30'h22), pk(5'd23, 8'h01, 30'h23), '0, '0);
        step(2'b11, pk(5'd24, 8'h01, 30'h24), pk(5'd25, 8'h01, 30'h25), '0, '0);
        chk("ovf_set", 64'(err_overflow), 64'(1'b1));
        step(2'b00, nil, nil, '0, '0);
        chk("ovf_sticky", 64'(err_overflow), 64'(1'b1));
        reset = 1'b0;
        #1;
        chk("mid_rst_wr_en", 64'(btb_wr_en), 64'(1'b0));
        chk("mid_rst_count", 64'(dut.count), 64'(0));
        chk("mid_rst_ovf", 64'(err_overflow), 64'(1'b0));
        chk("mid_rst_ready", 64'(upd_ready), 64'(1'b1));
        exp_q.delete();
        exp_ovf = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        idle(3);
        step(2'b01, pk(5'd30, 8'h33, 30'h3030), nil, '0, '0);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
